mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_access.sv | 153 +++++++++++++++
 tb/tb_mem_access.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Memory-side bus of the mem_access stage: one outstanding word request,
// completed by a mem_ready pulse that also qualifies mem_rdata.
interface mem_access_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_access.sv
// Pipeline memory-access stage: holds one op, issues its word access and stalls upstream until mem_ready.
// Define MEM_ACCESS_MISALIGN_EN to trap misaligned half/word accesses instead of issuing them.
module mem_access (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_MemRead,
   input  logic         in_MemWrite,
   input  logic         in_RegWrite,
   input  logic         in_MemToReg,
   input  logic [4:0]   in_RegDest,
   input  logic [2:0]   in_funct3,
   input  logic [31:0]  alu_result,
   input  logic [31:0]  rs2_value,
   output logic         stall,
   mem_access_if.master bus,
   output logic         out_RegWrite,
   output logic         out_MemToReg,
   output logic [4:0]   out_RegDest,
   output logic [31:0]  out_alu_result,
   output logic [31:0]  out_mem_data,
   output logic         out_misaligned
);

   typedef enum logic {IDLE, ACCESS} state_t;

   typedef struct packed {
      logic        memRead;
      logic        regWrite;
      logic        memToReg;
      logic        misaligned;
      logic [4:0]  regDest;
      logic [2:0]  funct3;
      logic [31:0] alu;
   } op_t;

   state_t      state, nextState;
   op_t         held, capOp;
   logic [1:0]  lane;
   logic [3:0]  capStrb;
   logic [31:0] capWdata;
   logic        capMis;
   logic        capMem;
   logic [7:0]  ldByte;
   logic [15:0] ldHalf;
   logic [31:0] loadData;

   assign lane   = alu_result[1:0];
   assign capMem = in_MemRead | in_MemWrite;

`ifdef MEM_ACCESS_MISALIGN_EN
   logic isByte, isHalf;
   // Loads use funct3[2] as the unsigned flag; stores treat anything past 001 as a word.
   always_comb begin
      isByte = in_MemWrite ? (in_funct3 == 3'b000) : (in_funct3[1:0] == 2'b00);
      isHalf = in_MemWrite ? (in_funct3 == 3'b001) : (in_funct3[1:0] == 2'b01);
   end
   assign capMis = capMem && (isHalf ? lane[0] : (!isByte && (lane != 2'b00)));
`else
   assign capMis = 1'b0;
`endif

   always_comb begin
      capStrb  = 4'b1111;
      capWdata = rs2_value;
      case (in_funct3)
         3'b000: begin
            capStrb  = 4'b0001 << lane;
            capWdata = {4{rs2_value[7:0]}};
         end
         3'b001: begin
            capStrb  = 4'b0011 << {lane[1], 1'b0};
            capWdata = {2{rs2_value[15:0]}};
         end
         default: ;
      endcase
      if (!in_MemWrite) capStrb = 4'b0000;
   end

   always_comb begin
      capOp            = '0;
      capOp.memRead    = in_MemRead;
      capOp.regWrite   = in_RegWrite;
      capOp.memToReg   = in_MemToReg;
      capOp.misaligned = capMis;
      capOp.regDest    = in_RegDest;
      capOp.funct3     = in_funct3;
      capOp.alu        = alu_result;
   end

   always_comb begin
      ldByte = bus.mem_rdata[7:0];
      case (held.alu[1:0])
         2'd1:    ldByte = bus.mem_rdata[15:8];
         2'd2:    ldByte = bus.mem_rdata[23:16];
         2'd3:    ldByte = bus.mem_rdata[31:24];
         default: ;
      endcase
      ldHalf = held.alu[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      case (held.funct3)
         3'b000:  loadData = {{24{ldByte[7]}}, ldByte};
         3'b100:  loadData = {24'h0, ldByte};
         3'b001:  loadData = {{16{ldHalf[15]}}, ldHalf};
         3'b101:  loadData = {16'h0, ldHalf};
         default: loadData = bus.mem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   // Any edge without stall both retires the held op and captures the next one.
   always_comb begin
      stall     = (state == ACCESS) && !bus.mem_ready;
      nextState = state;
      if (!stall) nextState = (capMem && !capMis) ? ACCESS : IDLE;
   end

   assign bus.mem_req = (state == ACCESS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         held           <= '0;
         bus.mem_we     <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_wstrb  <= '0;
         out_RegWrite   <= 1'b0;
         out_MemToReg   <= 1'b0;
         out_RegDest    <= '0;
         out_alu_result <= '0;
         out_mem_data   <= '0;
         out_misaligned <= 1'b0;
      end else if (!stall) begin
         out_RegWrite   <= held.regWrite && !held.misaligned;
         out_MemToReg   <= held.memToReg;
         out_RegDest    <= held.regDest;
         out_alu_result <= held.alu;
         out_mem_data   <= (held.memRead && !held.misaligned) ? loadData : 32'h0;
         out_misaligned <= held.misaligned;
         held           <= capOp;
         bus.mem_we     <= in_MemWrite;
         bus.mem_addr   <= {alu_result[31:2], 2'b00};
         bus.mem_wdata  <= capWdata;
         bus.mem_wstrb  <= capStrb;
      end else begin
         out_RegWrite   <= 1'b0;
         out_misaligned <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a scoreboard queue holds expected write-back results,
// popped by a monitor whenever out_RegWrite is seen.
module tb_mem_access;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_MemRead, in_MemWrite, in_RegWrite, in_MemToReg;
   logic [4:0]  in_RegDest;
   logic [2:0]  in_funct3;
   logic [31:0] alu_result, rs2_value;
   logic        stall, out_RegWrite, out_MemToReg, out_misaligned;
   logic [4:0]  out_RegDest;
   logic [31:0] out_alu_result, out_mem_data;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] data;
      logic        m2r;
   } exp_t;

   exp_t sbq[$];
   int   nAssert = 0;
   int   nFail   = 0;

   mem_access_if bus();

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst),
      .in_MemRead(in_MemRead), .in_MemWrite(in_MemWrite),
      .in_RegWrite(in_RegWrite), .in_MemToReg(in_MemToReg),
      .in_RegDest(in_RegDest), .in_funct3(in_funct3),
      .alu_result(alu_result), .rs2_value(rs2_value),
      .stall(stall), .bus(bus),
      .out_RegWrite(out_RegWrite), .out_MemToReg(out_MemToReg),
      .out_RegDest(out_RegDest), .out_alu_result(out_alu_result),
      .out_mem_data(out_mem_data), .out_misaligned(out_misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setOp(input logic rd, input logic wr, input logic rw, input logic m2r,
                        input logic [4:0] dst, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2);
      in_MemRead = rd; in_MemWrite = wr; in_RegWrite = rw; in_MemToReg = m2r;
      in_RegDest = dst; in_funct3 = f3; alu_result = alu; rs2_value = rs2;
   endtask

   task automatic setNop();
      setOp(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 32'h0, 32'h0);
   endtask

   task automatic pushExp(input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] data, input logic m2r);
      exp_t e;
      e.rd = rd; e.alu = alu; e.data = data; e.m2r = m2r;
      sbq.push_back(e);
   endtask

   // Called one step after a capture edge; mem_ready rises in cycle lat and the
   // task returns one step after the completion edge.
   task automatic serve(input int lat, input logic [31:0] rdata,
                        output int reqCycles, output int stallCycles);
      reqCycles = 0; stallCycles = 0;
      for (int c = 1; c <= lat; c++) begin
         bus.mem_ready = (c == lat);
         bus.mem_rdata = rdata;
         #1;
         if (bus.mem_req) reqCycles++;
         if (stall) stallCycles++;
         tick();
      end
      bus.mem_ready = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst && out_RegWrite) begin
         if (sbq.size() == 0) begin
            chk("unexpected_writeback", 32'(out_RegDest), 32'h0);
            chk("unexpected_writeback_q", 32'h1, 32'h0 + 32'(sbq.size()));
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("wb_rd",   32'(out_RegDest),  32'(e.rd));
            chk("wb_alu",  out_alu_result,    e.alu);
            chk("wb_data", out_mem_data,      e.data);
            chk("wb_m2r",  32'(out_MemToReg), 32'(e.m2r));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int rq, st;
      logic [31:0] ldAddr [5]  = '{32'h22, 32'h101, 32'h102, 32'h20, 32'h30};
      logic [2:0]  ldF3   [5]  = '{3'b001, 3'b100, 3'b000, 3'b001, 3'b011};
      logic [31:0] ldRd   [5]  = '{32'h8001_0000, 32'h0000_F000, 32'h007F_0000, 32'h0000_7FFE, 32'hDEAD_BEEF};
      logic [31:0] ldExp  [5]  = '{32'hFFFF_8001, 32'h0000_00F0, 32'h0000_007F, 32'h0000_7FFE, 32'hDEAD_BEEF};
      logic [31:0] stAddr [5]  = '{32'h1, 32'h202, 32'h200, 32'h8, 32'h3};
      logic [2:0]  stF3   [5]  = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b000};
      logic [31:0] stRs2  [5]  = '{32'h1234_56EF, 32'h0000_BEEF, 32'h0000_1357, 32'hA5A5_0F0F, 32'h0000_00C3};
      logic [3:0]  stStrb [5]  = '{4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1000};
      logic [31:0] stData [5]  = '{32'hEFEF_EFEF, 32'hBEEF_BEEF, 32'h1357_1357, 32'hA5A5_0F0F, 32'hC3C3_C3C3};

      rst = 1'b1;
      setNop();
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      #2;
      chk("rst_mem_req",  32'(bus.mem_req),     32'h0);
      chk("rst_stall",    32'(stall),           32'h0);
      chk("rst_regwrite", 32'(out_RegWrite),    32'h0);
      chk("rst_memdata",  out_mem_data,         32'h0);
      chk("rst_misalign", 32'(out_misaligned),  32'h0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      tick();

      // ALU op passes through in one cycle without stalling
      setOp(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 3'b010, 32'h1234, 32'h0);
      pushExp(5'd5, 32'h1234, 32'h0, 1'b0);
      tick();
      setNop();
      chk("alu_stall",    32'(stall),        32'h0);
      chk("alu_mem_req",  32'(bus.mem_req),  32'h0);
      chk("alu_lat0",     32'(out_RegWrite), 32'h0);
      tick();
      chk("alu_lat1",     32'(out_RegWrite), 32'h1);
      chk("alu_stall2",   32'(stall),        32'h0);

      // LB with a three-cycle memory
      setOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 3'b000, 32'h103, 32'h0);
      pushExp(5'd7, 32'h103, 32'hFFFF_FF80, 1'b1);
      tick();
      setNop();
      chk("lb_addr", bus.mem_addr,     32'h100);
      chk("lb_we",   32'(bus.mem_we),  32'h0);
      serve(3, 32'h80FF_FF00, rq, st);
      chk("lb_req_cycles",   32'(rq), 32'd3);
      chk("lb_stall_cycles", 32'(st), 32'd2);
      chk("lb_req_after",    32'(bus.mem_req), 32'h0);

      // Stores: strobe and replicated data per size/lane
      for (int i = 0; i < 5; i++) begin
         setOp(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, stF3[i], stAddr[i], stRs2[i]);
         tick();
         setNop();
         chk($sformatf("st%0d_we", i),    32'(bus.mem_we),    32'h1);
         chk($sformatf("st%0d_addr", i),  bus.mem_addr,       {stAddr[i][31:2], 2'b00});
         chk($sformatf("st%0d_strb", i),  32'(bus.mem_wstrb), 32'(stStrb[i]));
         chk($sformatf("st%0d_wdata", i), bus.mem_wdata,      stData[i]);
         serve(1, 32'h0, rq, st);
         chk($sformatf("st%0d_req_cycles", i), 32'(rq), 32'd1);
         chk($sformatf("st%0d_stall", i),      32'(st), 32'd0);
      end

      // Loads: extension by size, sign and lane
      for (int i = 0; i < 5; i++) begin
         setOp(1'b1, 1'b0, 1'b1, 1'b1, 5'(10 + i), ldF3[i], ldAddr[i], 32'h0);
         pushExp(5'(10 + i), ldAddr[i], ldExp[i], 1'b1);
         tick();
         setNop();
         chk($sformatf("ld%0d_addr", i), bus.mem_addr, {ldAddr[i][31:2], 2'b00});
         serve(1, ldRd[i], rq, st);
         chk($sformatf("ld%0d_req_cycles", i), 32'(rq), 32'd1);
      end

      // Back-to-back LW then LHU with mem_ready held high
      setOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 3'b010, 32'h10, 32'h0);
      pushExp(5'd3, 32'h10, 32'hCAFE_1234, 1'b1);
      pushExp(5'd4, 32'h12, 32'h0000_ABCD, 1'b1);
      tick();
      setOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 3'b101, 32'h12, 32'h0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hCAFE_1234;
      #1;
      chk("b2b_req0",   32'(bus.mem_req), 32'h1);
      chk("b2b_stall0", 32'(stall),       32'h0);
      tick();
      setNop();
      bus.mem_rdata = 32'hABCD_5678;
      #1;
      chk("b2b_req1",   32'(bus.mem_req), 32'h1);
      chk("b2b_addr1",  bus.mem_addr,     32'h10);
      tick();
      bus.mem_ready = 1'b0;
      #1;
      chk("b2b_req2",   32'(bus.mem_req), 32'h0);

      // Reset during the second cycle of an access
      setOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 3'b010, 32'h40, 32'h0);
      tick();
      setNop();
      chk("rstmid_req0", 32'(bus.mem_req), 32'h1);
      tick();
      chk("rstmid_stall_pre", 32'(stall), 32'h1);
      #1;
      rst = 1'b1;
      #1;
      chk("rstmid_req",      32'(bus.mem_req),    32'h0);
      chk("rstmid_stall",    32'(stall),          32'h0);
      chk("rstmid_regwrite", 32'(out_RegWrite),   32'h0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rstmid_idle_req",   32'(bus.mem_req), 32'h0);
      chk("rstmid_idle_stall", 32'(stall),       32'h0);

`ifdef MEM_ACCESS_MISALIGN_EN
      setOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 3'b010, 32'h6, 32'h0);
      tick();
      setNop();
      chk("mis_req",       32'(bus.mem_req),    32'h0);
      chk("mis_flag0",     32'(out_misaligned), 32'h0);
      tick();
      chk("mis_flag1",     32'(out_misaligned), 32'h1);
      chk("mis_regwrite",  32'(out_RegWrite),   32'h0);
      tick();
      chk("mis_flag2",     32'(out_misaligned), 32'h0);
`else
      setOp(1'b1, 1'b0, 1'b1, 1'b1, 5'd2, 3'b010, 32'h6, 32'h0);
      pushExp(5'd2, 32'h6, 32'h1122_3344, 1'b1);
      tick();
      setNop();
      chk("mis_req",  32'(bus.mem_req), 32'h1);
      chk("mis_addr", bus.mem_addr,     32'h4);
      serve(1, 32'h1122_3344, rq, st);
      chk("mis_flag", 32'(out_misaligned), 32'h0);
`endif

      tick();
      tick();
      chk("sb_empty", 32'(sbq.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule
